// File: rtl/bram_arb_pkg.sv
// Shared definitions for the block-RAM port arbiter: default geometry,
// mailbox address, pipeline owner tags and a width helper.
package bram_arb_pkg;

    localparam int AW_DEF = 13;
    localparam int DW_DEF = 8;
    localparam logic [12:0] IRQ_ADDR_DEF = 13'h1FFF;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_FAB  = 2'd2
    } owner_e;

    // Never returns 0 so a single requester still gets a 1-bit index.
    function automatic int clog2(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotate-priority selector: the first set request found searching upward
// from ptr+1 (wrapping) wins.
module rr_pick #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] idx,
    output logic          any
);

    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!any && req[i] && (((int'(ptr) + k) % N) == i)) begin
                    any    = 1'b1;
                    gnt[i] = 1'b1;
                    idx    = PW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Arbitrates one single-port BRAM between a zero-wait CPU bus and N_REQ
// round-robin fabric requesters, with a write-to-raise mailbox interrupt.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int            N_REQ    = 2,
    parameter int            AW       = AW_DEF,
    parameter int            DW       = DW_DEF,
    parameter logic [AW-1:0] IRQ_ADDR = AW'(IRQ_ADDR_DEF)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                cpu_we,
    input  logic                cpu_re,
    input  logic [AW-1:0]       cpu_addr,
    input  logic [DW-1:0]       cpu_wdata,
    output logic [DW-1:0]       cpu_rdata,
    output logic                cpu_rvalid,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ-1:0]    we_i,
    input  logic [N_REQ*AW-1:0] addr_i,
    input  logic [N_REQ*DW-1:0] wdata_i,
    output logic [N_REQ-1:0]    gnt,
    output logic [N_REQ-1:0]    rvalid,
    output logic [DW-1:0]       rdata,
    output logic                bram_we,
    output logic [AW-1:0]       bram_addr,
    output logic [DW-1:0]       bram_di,
    input  logic [DW-1:0]       bram_do,
    output logic                irq
);

    localparam int PW = clog2(N_REQ);

    logic [N_REQ-1:0] w_pick_gnt;
    logic [PW-1:0]    w_pick_idx;
    logic             w_pick_any;
    logic             w_cpu_slot;
    logic             w_fab_slot;
    logic             w_fab_we;
    logic [AW-1:0]    w_fab_addr;
    logic [DW-1:0]    w_fab_wdata;
    logic             w_irq_hit;

    logic [PW-1:0]    r_ptr;
    logic             r_bram_we;
    logic [AW-1:0]    r_bram_addr;
    logic [DW-1:0]    r_bram_di;
    owner_e           r_s1_own;
    logic [PW-1:0]    r_s1_idx;
    owner_e           r_s2_own;
    logic [PW-1:0]    r_s2_idx;
    logic             r_irq;

    rr_pick #(
        .N  (N_REQ),
        .PW (PW)
    ) u_pick (
        .req (req),
        .ptr (r_ptr),
        .gnt (w_pick_gnt),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    // The CPU bus cannot stall, so any CPU strobe takes the slot outright.
    assign w_cpu_slot = cpu_we | cpu_re;
    assign w_fab_slot = !w_cpu_slot && w_pick_any;
    assign gnt        = (reset && w_fab_slot) ? w_pick_gnt : '0;

    always_comb begin
        w_fab_we    = 1'b0;
        w_fab_addr  = '0;
        w_fab_wdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_pick_idx == PW'(i)) begin
                w_fab_we    = we_i[i];
                w_fab_addr  = addr_i[AW*i +: AW];
                w_fab_wdata = wdata_i[DW*i +: DW];
            end
        end
    end

    // Stage 1: the accepted command drives the BRAM port for one cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr       <= PW'(N_REQ - 1);
            r_bram_we   <= 1'b0;
            r_bram_addr <= '0;
            r_bram_di   <= '0;
            r_s1_own    <= OWN_NONE;
            r_s1_idx    <= '0;
        end else if (w_cpu_slot) begin
            r_bram_we   <= cpu_we;
            r_bram_addr <= cpu_addr;
            if (cpu_we) begin
                r_bram_di <= cpu_wdata;
            end
            r_s1_own    <= OWN_CPU;
            r_s1_idx    <= '0;
        end else if (w_fab_slot) begin
            r_bram_we   <= w_fab_we;
            r_bram_addr <= w_fab_addr;
            if (w_fab_we) begin
                r_bram_di <= w_fab_wdata;
            end
            r_s1_own    <= OWN_FAB;
            r_s1_idx    <= w_pick_idx;
            r_ptr       <= w_pick_idx;
        end else begin
            r_bram_we   <= 1'b0;
            r_s1_own    <= OWN_NONE;
        end
    end

    // Stage 2 only tracks reads; writes retire once they leave the port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s2_own <= OWN_NONE;
            r_s2_idx <= '0;
        end else begin
            r_s2_own <= r_bram_we ? OWN_NONE : r_s1_own;
            r_s2_idx <= r_s1_idx;
        end
    end

    assign w_irq_hit = (r_bram_addr == IRQ_ADDR);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_irq <= 1'b0;
        end else if (w_irq_hit && r_bram_we && (r_s1_own == OWN_FAB)) begin
            r_irq <= 1'b1;
        end else if (w_irq_hit && !r_bram_we && (r_s1_own == OWN_CPU)) begin
            r_irq <= 1'b0;
        end
    end

    always_comb begin
        rvalid = '0;
        for (int i = 0; i < N_REQ; i++) begin
            rvalid[i] = (r_s2_own == OWN_FAB) && (r_s2_idx == PW'(i));
        end
    end

    assign cpu_rvalid = (r_s2_own == OWN_CPU);
    assign cpu_rdata  = bram_do;
    assign rdata      = bram_do;
    assign bram_we    = r_bram_we;
    assign bram_addr  = r_bram_addr;
    assign bram_di    = r_bram_di;
    assign irq        = r_irq;

endmodule

// File: doc/bram_port_arbiter.md
Name: bram_port_arbiter

Overview:
- Shares one single-port block-RAM array (13-bit address, 8-bit data) between the CPU SRAM-bus write/read path and N_REQ fabric-side requesters.
- CPU accesses have absolute priority, because the CPU bus has no wait state. Fabric requesters are served round-robin with a req/gnt handshake.
- Also provides a mailbox interrupt to the CPU: a fabric write to IRQ_ADDR raises irq, and a CPU read of IRQ_ADDR clears it.
- Sits between the bus-synchronising front end and the RAMB16 primitives. The BRAM is clocked on clk posedge.

Parameters:
- N_REQ, 2, number of fabric requesters (2..4).
- AW, 13, address width.
- DW, 8, data width.
- IRQ_ADDR, 13'h1FFF, mailbox address.

Ports:
- clk  in  1  system clock, all logic on posedge
- reset  in  1  asynchronous, active-low reset
- cpu_we  in  1  one-cycle CPU write strobe (already synchronised)
- cpu_re  in  1  one-cycle CPU read strobe
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_rdata  out  DW  CPU read data
- cpu_rvalid  out  1  cpu_rdata valid (one-cycle pulse)
- req  in  N_REQ  fabric request, held until granted
- we_i  in  N_REQ  per-requester write (1) / read (0)
- addr_i  in  N_REQ*AW  requester i at [AW*i +: AW]
- wdata_i  in  N_REQ*DW  requester i at [DW*i +: DW]
- gnt  out  N_REQ  one-hot, combinational, command accepted this cycle
- rvalid  out  N_REQ  one-hot read-data-valid pulse
- rdata  out  DW  shared fabric read data
- bram_we  out  1  BRAM write enable (registered)
- bram_addr  out  AW  BRAM address (registered)
- bram_di  out  DW  BRAM write data (registered)
- bram_do  in  DW  BRAM read data (synchronous, 1-cycle latency)
- irq  out  1  mailbox interrupt, level

Behaviour:
- Reset (reset=0, asynchronous):
  - bram_we, bram_addr, bram_di, cpu_rvalid, rvalid, irq and all pipeline valid bits go to 0.
  - RR pointer resets to N_REQ-1, so requester 0 wins first.
  - gnt is 0 while reset is asserted.
- Acceptance in cycle t:
  - If cpu_we|cpu_re: the CPU owns the slot and gnt = 0. cpu_we takes precedence if both strobes are set.
  - Otherwise, if any req: pick the first set req searching from ptr+1 (mod N_REQ), assert that gnt bit in cycle t, and set ptr to the winner at the t edge.
  - ptr is unchanged when there is no fabric grant.
- Pipeline:
  - Accepted command is registered onto the bram_* ports during t+1.
  - BRAM samples at the end of t+1, and bram_do is valid in t+2.
  - For reads: cpu_rvalid or rvalid[i] pulses in t+2, with cpu_rdata/rdata = bram_do. Owner and requester index are carried in a 2-stage tag pipeline.
  - Writes produce no rvalid.
  - Throughput is one access per cycle; back-to-back grants are allowed.
- Handshake: the requester must update req, we_i, addr_i and wdata_i at the edge following gnt. A req held high is a new request.
- Idle cycle: bram_we = 0; bram_addr holds its last value.
- irq:
  - Set at the end of t+1 when a fabric write to IRQ_ADDR is on the bram port.
  - Cleared at the end of t+1 when a CPU read of IRQ_ADDR is on the port.
  - CPU writes and fabric reads to IRQ_ADDR do not affect irq.
  - One owner per slot, so set and clear never coincide. Later events override earlier ones.
- Starvation: a CPU strobe blocks at most one fabric slot per CPU bus cycle. No fabric requester waits more than N_REQ fabric-free slots.
- Reset mid-operation: in-flight commands and pending rvalid pulses are dropped; no partial write is issued after reset release.

Decomposition:
- Package bram_arb_pkg holds:
  - AW/DW defaults and IRQ_ADDR;
  - owner tag encoding OWN_NONE=2'd0, OWN_CPU=2'd1, OWN_FAB=2'd2;
  - function clog2 for ptr/index width.
- Sub-module rr_pick: combinational rotate-priority selector.
  - Inputs: req, ptr.
  - Outputs: one-hot gnt, encoded index, any.
- The top level holds ptr, the bram port registers, the tag pipeline and irq.

Test Plan:
- Reset: hold reset=0 with req=2'b11 -> gnt=0, rvalid=0, irq=0, bram_we=0. Release -> first grant is gnt=2'b01.
- CPU write then read: cpu_we addr 0x0010 data 0xA5, then cpu_re 0x0010 three cycles later -> cpu_rvalid exactly 2 cycles after cpu_re, cpu_rdata=0xA5.
- Round-robin fairness: req=2'b11 held for 6 cycles -> gnt sequence 01,10,01,10,01,10, bram_addr follows addr_i with 1-cycle lag.
- CPU pre-emption: req[0] read of 0x0020 with cpu_re 0x0030 in the same cycle -> gnt=0 that cycle, gnt[0] next cycle. cpu_rvalid precedes rvalid[0] by one cycle, each with correct data.
- Mailbox: requester 1 writes 0x5A to 0x1FFF -> irq=1 two cycles after gnt[1]. CPU read of 0x1FFF -> cpu_rdata=0x5A, irq=0 two cycles after cpu_re. CPU write to 0x1FFF leaves irq unchanged.
- Reset mid-operation: fabric read granted, reset asserted the next cycle -> no rvalid pulse, irq=0, ptr reset (next grant goes to requester 0).
